bcd_conv_ctrl: RTL and testbench

BCD_CONV_CTRL -- requirements
Module: bcd_conv_ctrl

---
 rtl/bcd_pkg.sv | 33 +++
 rtl/bcd_digit_adj.sv | 20 ++
 rtl/bcd_conv_ctrl.sv | 111 +++++++++++
 tb/tb_bcd_conv_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

  // True when DIGITS decimal digits can hold every WIDTH-bit unsigned value,
  // i.e. 10^digits >= 2^width. Limited to operands below 127 bits.
  function automatic bit bcd_fits(input int digits, input int width);
    logic [127:0] p10;
    logic [127:0] p2;
    p10 = 128'd1;
    for (int i = 0; i < digits; i++) begin
      if (i < 38) begin
        p10 = p10 * 128'd10;
      end else begin
        p10 = p10;
      end
    end
    if (width >= 127) begin
      return 1'b0;
    end else begin
      p2 = 128'd1 << width;
      return (p10 >= p2);
    end
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  // Conditional add-3 correction.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end else begin
      digit_out = digit_in;
    end
  end

endmodule

// File: rtl/bcd_conv_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3). One operand bit is
// consumed per CONV cycle; the result is published only in DONE.
module bcd_conv_ctrl
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           bin_in,
  output logic                       busy,
  output logic                       done,
  output logic [DIGIT_W*DIGITS-1:0]  bcd_out
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (!bcd_fits(DIGITS, WIDTH)) begin : g_range_err
    $error("bcd_conv_ctrl: DIGITS too small to represent every WIDTH-bit value");
  end

  bcd_state_e         state_r, state_s;
  logic [WIDTH-1:0]   sh_r, sh_s;
  logic [BCD_W-1:0]   acc_r, acc_s, acc_adj_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               busy_r, done_r;
  logic [BCD_W-1:0]   bcd_out_r;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (acc_r[g*DIGIT_W +: DIGIT_W]),
      .digit_out (acc_adj_s[g*DIGIT_W +: DIGIT_W])
    );
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sh_r    <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      sh_r    <= sh_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and datapath update: latch on start, adjust-then-shift in CONV.
  always_comb begin
    state_s = state_r;
    sh_s    = sh_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = CONV;
          sh_s    = bin_in;
          acc_s   = '0;
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      CONV: begin
        {acc_s, sh_s} = {acc_adj_s, sh_r} << 1'b1;
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Registered outputs, aligned with the state they describe; the result
  // register only loads on entry to DONE so partial sums never show.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      bcd_out_r <= '0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == DONE);
      if (state_s == DONE) begin
        bcd_out_r <= acc_s;
      end else begin
        bcd_out_r <= bcd_out_r;
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign bcd_out = bcd_out_r;

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// Directed self-checking bench for bcd_conv_ctrl (WIDTH=8, DIGITS=3).
module tb_bcd_conv_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  int          n_checks;
  int          n_fail;
  logic [11:0] last_exp;

  bcd_conv_ctrl #(.WIDTH(8), .DIGITS(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent decimal reference.
  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after the accepting edge (first CONV cycle, k=1).
  task automatic finish_conv(input logic [11:0] exp, input string tag);
    int k, busy_cnt;
    bit stable;
    k = 1; busy_cnt = 0; stable = 1'b1;
    while (done !== 1'b1 && k < 20) begin
      if (busy === 1'b1) busy_cnt++;
      if (bcd_out !== last_exp) stable = 1'b0;
      tick();
      k++;
    end
    if (busy === 1'b1) busy_cnt++;
    chk({tag, "_latency"}, k, 9);
    chk({tag, "_bcd"}, {20'd0, bcd_out}, {20'd0, exp});
    chk({tag, "_busy_cycles"}, busy_cnt, 9);
    chk({tag, "_bcd_stable"}, {31'd0, stable}, 32'd1);
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hold"}, {20'd0, bcd_out}, {20'd0, exp});
    last_exp = exp;
  endtask

  task automatic run_conv(input logic [7:0] v, input string tag);
    start = 1'b1;
    bin_in = v;
    tick();
    start = 1'b0;
    bin_in = ~v;
    finish_conv(ref_bcd(int'(v)), tag);
  endtask

  initial begin
    int k, ndone, last_t;
    n_checks = 0; n_fail = 0; last_exp = 12'h000;
    rst_n = 1'b0; start = 1'b0; bin_in = 8'd0;

    // Reset state
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bcd", {20'd0, bcd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Zero operand, then extremes and decade boundaries
    run_conv(8'd0, "zero");
    run_conv(8'd255, "v255");
    run_conv(8'd99, "v99");
    run_conv(8'd100, "v100");

    // Start pulsed mid-conversion is ignored
    start = 1'b1; bin_in = 8'd13;
    tick();
    start = 1'b0; bin_in = 8'd0;
    k = 1;
    repeat (3) begin tick(); k++; end
    start = 1'b1; bin_in = 8'd200;
    tick(); k++;
    start = 1'b0; bin_in = 8'd0;
    while (done !== 1'b1 && k < 20) begin tick(); k++; end
    chk("ign_latency", k, 9);
    chk("ign_bcd", {20'd0, bcd_out}, 32'h013);
    ndone = 0;
    repeat (15) begin tick(); if (done === 1'b1) ndone++; end
    chk("ign_no_second_done", ndone, 0);
    chk("ign_hold", {20'd0, bcd_out}, 32'h013);
    last_exp = 12'h013;

    // Start held high: back-to-back every WIDTH+2 cycles
    start = 1'b1; bin_in = 8'd42;
    k = 0; ndone = 0; last_t = 0;
    for (int c = 0; c < 35; c++) begin
      tick(); k++;
      if (done === 1'b1) begin
        ndone++;
        chk("b2b_bcd", {20'd0, bcd_out}, 32'h042);
        if (ndone > 1) chk("b2b_period", k - last_t, 10);
        last_t = k;
      end
    end
    chk("b2b_count", ndone, 3);
    start = 1'b0;
    k = 0;
    while (busy !== 1'b0 && k < 20) begin tick(); k++; end
    chk("b2b_drain", {31'd0, busy}, 32'd0);
    last_exp = 12'h042;

    // Reset in the 4th CONV cycle aborts with no done pulse
    start = 1'b1; bin_in = 8'd77;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("abort_pre_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_bcd", {20'd0, bcd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin tick(); if (done === 1'b1 || busy === 1'b1) ndone++; end
    chk("abort_quiet", ndone, 0);
    last_exp = 12'h000;

    // Start accepted on the first edge after reset release
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; bin_in = 8'd5;
    tick();
    chk("post_rst_accept", {31'd0, busy}, 32'd1);
    start = 1'b0; bin_in = 8'd0;
    finish_conv(12'h005, "post_rst");

    // Exhaustive sweep
    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), "sweep");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
